// File: rtl/viterbi_codec.sv
// rtl/viterbi_codec.sv - rate-1/2 K=3 convolutional encoder and hard-decision Viterbi decoder
module viterbi_codec #(
    parameter int TB_DEPTH = 16,
    parameter int METRIC_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_enable_i,
    input  logic       enc_d_i,
    output logic       enc_valid_o,
    output logic [1:0] enc_d_o,
    input  logic       dec_enable_i,
    input  logic [1:0] dec_d_i,
    output logic       dec_valid_o,
    output logic       dec_d_o
);

    localparam int CNT_W = $clog2(TB_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TB_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_DEPTH - 1);
    localparam logic [METRIC_W-1:0] M_INIT = {2'b01, {(METRIC_W-2){1'b0}}};

    logic [1:0] enc_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            enc_state   <= 2'b00;
            enc_d_o     <= 2'b00;
            enc_valid_o <= 1'b0;
        end else if (enc_enable_i) begin
            enc_d_o     <= {enc_d_i ^ enc_state[1] ^ enc_state[0], enc_d_i ^ enc_state[0]};
            enc_state   <= {enc_d_i, enc_state[1]};
            enc_valid_o <= 1'b1;
        end else begin
            enc_valid_o <= 1'b0;
        end
    end

    logic [METRIC_W-1:0] pm     [4];
    logic [TB_DEPTH-1:0] surv   [4];
    logic [METRIC_W-1:0] acs_m  [4];
    logic [METRIC_W-1:0] norm_m [4];
    logic [TB_DEPTH-1:0] acs_s  [4];
    logic [METRIC_W-1:0] min_m;
    logic [1:0]          best;
    logic [CNT_W-1:0]    sym_cnt;

    function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] ex);
        logic [1:0] d;
        d = rx ^ ex;
        return {1'b0, d[1]} + {1'b0, d[0]};
    endfunction

    function automatic logic [METRIC_W-1:0] sat_add(input logic [METRIC_W-1:0] a, input logic [1:0] b);
        logic [METRIC_W:0] s;
        s = {1'b0, a} + {{(METRIC_W-1){1'b0}}, b};
        return s[METRIC_W] ? {METRIC_W{1'b1}} : s[METRIC_W-1:0];
    endfunction

    // State {b,x} is reached from {x,0} or {x,1}; ties keep the s0=0 predecessor.
    always_comb begin
        logic                b_bit;
        logic                x_bit;
        logic [1:0]          pred0;
        logic [1:0]          pred1;
        logic [1:0]          exp0;
        logic [1:0]          exp1;
        logic [METRIC_W-1:0] c0;
        logic [METRIC_W-1:0] c1;
        b_bit = 1'b0;
        x_bit = 1'b0;
        pred0 = 2'b00;
        pred1 = 2'b00;
        exp0  = 2'b00;
        exp1  = 2'b00;
        c0    = '0;
        c1    = '0;
        for (int n = 0; n < 4; n++) begin
            b_bit = (n >= 2);
            x_bit = (n % 2 == 1);
            pred0 = {x_bit, 1'b0};
            pred1 = {x_bit, 1'b1};
            exp0  = {b_bit ^ x_bit, b_bit};
            exp1  = {~(b_bit ^ x_bit), ~b_bit};
            c0    = sat_add(pm[pred0], branch_metric(dec_d_i, exp0));
            c1    = sat_add(pm[pred1], branch_metric(dec_d_i, exp1));
            if (c1 < c0) begin
                acs_m[n] = c1;
                acs_s[n] = {surv[pred1][TB_DEPTH-2:0], b_bit};
            end else begin
                acs_m[n] = c0;
                acs_s[n] = {surv[pred0][TB_DEPTH-2:0], b_bit};
            end
        end
        min_m = acs_m[0];
        best  = 2'd0;
        for (int n = 1; n < 4; n++) begin
            if (acs_m[n] < min_m) begin
                min_m = acs_m[n];
                best  = 2'(n);
            end
        end
        for (int n = 0; n < 4; n++) begin
            norm_m[n] = acs_m[n] - min_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pm[0] <= '0;
            for (int i = 1; i < 4; i++) pm[i] <= M_INIT;
            for (int i = 0; i < 4; i++) surv[i] <= '0;
            sym_cnt     <= '0;
            dec_valid_o <= 1'b0;
            dec_d_o     <= 1'b0;
        end else if (dec_enable_i) begin
            for (int i = 0; i < 4; i++) begin
                pm[i]   <= norm_m[i];
                surv[i] <= acs_s[i];
            end
            if (sym_cnt != CNT_MAX) sym_cnt <= sym_cnt + 1'b1;
            dec_valid_o <= (sym_cnt >= CNT_LAST);
            dec_d_o     <= acs_s[best][TB_DEPTH-1];
        end else begin
            dec_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_viterbi_codec.sv
// tb/tb_viterbi_codec.sv - scoreboard bench for viterbi_codec with loopback channel model
module tb_viterbi_codec;

    localparam int TB_DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enc_enable_i = 1'b0;
    logic       enc_d_i = 1'b0;
    logic       enc_valid_o;
    logic [1:0] enc_d_o;
    logic       dec_enable_i = 1'b0;
    logic [1:0] dec_d_i = 2'b00;
    logic       dec_valid_o;
    logic       dec_d_o;

    viterbi_codec #(.TB_DEPTH(TB_DEPTH), .METRIC_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .enc_enable_i (enc_enable_i),
        .enc_d_i      (enc_d_i),
        .enc_valid_o  (enc_valid_o),
        .enc_d_o      (enc_d_o),
        .dec_enable_i (dec_enable_i),
        .dec_d_i      (dec_d_i),
        .dec_valid_o  (dec_valid_o),
        .dec_d_o      (dec_d_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] d;
        int         cyc;
    } exp_t;

    exp_t enc_q[$];
    exp_t dec_q[$];
    logic hist[$];
    logic dec_hist[$];

    int   checks = 0;
    int   errors = 0;
    int   rst_cycle = -10;
    bit   armed = 1'b0;
    bit   inject = 1'b0;
    logic [31:0] word_count = 0;

    logic       pipe_v = 1'b0;
    logic [1:0] pipe_d = 2'b00;
    logic       pipe_b = 1'b0;
    logic       s1_en = 1'b0;
    logic       s1_b = 1'b0;

    task automatic check(input string name, input int c, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d got %b want %b", name, c, got, want);
        end
    endtask

    // One clock of stimulus: channel register forwards last cycle's encoder symbol.
    task automatic step(input logic en, input logic b, input logic do_rst);
        int   n;
        int   k;
        logic x1;
        logic x2;
        @(posedge clk);
        #1;
        n = cyc;
        dec_enable_i = pipe_v;
        dec_d_i = pipe_d ^ ((inject && pipe_v && word_count[3:1] == 3'b111) ? 2'b10 : 2'b00);
        if (pipe_v && !do_rst) begin
            word_count++;
            dec_hist.push_back(pipe_b);
            k = dec_hist.size();
            if (k >= TB_DEPTH) dec_q.push_back('{d: {1'b0, dec_hist[k-TB_DEPTH]}, cyc: n + 1});
        end
        pipe_v = s1_en;
        pipe_d = enc_d_o;
        pipe_b = s1_b;
        rst = do_rst;
        enc_enable_i = en;
        enc_d_i = b;
        s1_en = en && !do_rst;
        s1_b = b;
        if (do_rst) begin
            while (enc_q.size() > 0 && enc_q[$].cyc > n) void'(enc_q.pop_back());
            while (dec_q.size() > 0 && dec_q[$].cyc > n) void'(dec_q.pop_back());
            hist.delete();
            dec_hist.delete();
            pipe_v = 1'b0;
            s1_en = 1'b0;
            word_count = 0;
            rst_cycle = n;
        end else if (en) begin
            x1 = (hist.size() >= 1) ? hist[$] : 1'b0;
            x2 = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
            enc_q.push_back('{d: {b ^ x1 ^ x2, b ^ x2}, cyc: n + 1});
            hist.push_back(b);
        end
    endtask

    task automatic stream(input int nbits, input bit zeros);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            b = zeros ? 1'b0 : 1'($urandom_range(1, 0));
            step(1'b1, b, 1'b0);
        end
    endtask

    int         mon_c;
    bit         ev;
    exp_t       e;
    logic [1:0] last_enc = 2'b00;
    logic       last_dec = 1'b0;

    always @(negedge clk) begin
        if (armed) begin
            mon_c = cyc;
            if (mon_c == rst_cycle + 1) begin
                last_enc = 2'b00;
                last_dec = 1'b0;
            end
            ev = (enc_q.size() > 0) && (enc_q[0].cyc == mon_c);
            if (ev) begin
                e = enc_q.pop_front();
                last_enc = e.d;
            end
            check("enc_valid", mon_c, {1'b0, enc_valid_o}, {1'b0, ev});
            check("enc_d", mon_c, enc_d_o, last_enc);
            ev = (dec_q.size() > 0) && (dec_q[0].cyc == mon_c);
            if (ev) begin
                e = dec_q.pop_front();
                last_dec = e.d[0];
            end
            check("dec_valid", mon_c, {1'b0, dec_valid_o}, {1'b0, ev});
            check("dec_d", mon_c, {1'b0, dec_d_o}, {1'b0, last_dec});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycle %0d got timeout want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic vec [6];
        vec = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        armed = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        foreach (vec[i]) step(1'b1, vec[i], 1'b0);
        step(1'b0, 1'b0, 1'b1);
        stream(64, 1'b1);
        stream(256, 1'b0);
        inject = 1'b1;
        stream(256, 1'b0);
        inject = 1'b0;
        stream(40, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        stream(40, 1'b0);
        step(1'b1, 1'($urandom_range(1, 0)), 1'b1);
        stream(100, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/viterbi_codec.md
Name: viterbi_codec

Overview:
Rate-1/2, constraint-length-3 convolutional encoder plus hard-decision Viterbi decoder, in one block with independent encode and decode paths.
- The encoder feeds a channel model, which may inject bit errors; the channel output feeds the decoder.
- The decoder recovers the original bit stream with fixed latency, correcting sparse channel errors.
- Used in the tx/rx loopback subsystem.

Parameters:
- TB_DEPTH, 16: survivor path length in symbols; this is the decode latency. Legal range 8..32.
- METRIC_W, 8: path metric width in bits.

Ports:
- clk, input, 1: single clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- enc_enable_i, input, 1: encoder consumes enc_d_i this cycle.
- enc_d_i, input, 1: information bit to encode.
- enc_valid_o, output, 1: enc_d_o holds a new symbol.
- enc_d_o, output, 2: encoded symbol {p1, p0}.
- dec_enable_i, input, 1: decoder consumes dec_d_i this cycle.
- dec_d_i, input, 2: received hard-decision symbol {p1, p0}.
- dec_valid_o, output, 1: dec_d_o holds a decoded bit.
- dec_d_o, output, 1: decoded information bit.

Behaviour:
Trellis:
- State is {s1, s0}: s1 is the previous input bit, s0 the one before it; 4 states.
- Input b moves the state to {b, s1}.
- Output symbol: p1 = b^s1^s0 (generator 7 octal), p0 = b^s0 (generator 5 octal).

Encoder:
- Reset: state 00, enc_d_o = 00, enc_valid_o = 0.
- When enc_enable_i = 1: register enc_d_o from the current state and enc_d_i, update the state, set enc_valid_o = 1 on the next cycle. Latency is 1 cycle.
- When enc_enable_i = 0: state and enc_d_o hold, enc_valid_o = 0.

Decoder, per enabled cycle (one symbol):
- Branch metric: Hamming distance between dec_d_i and the expected symbol, value 0..2.
- ACS:
  - Predecessors of state {b, x} are {x, 0} and {x, 1}.
  - New metric = min(pred metric + branch metric).
  - On a tie, choose the predecessor with s0 = 0.
- Path metrics:
  - Reset: state 00 = 0, all other states = 2^(METRIC_W-2).
  - Normalisation: subtract the minimum new metric from all four every step, so the minimum metric is always 0.
  - Add saturates at 2^METRIC_W − 1.
- Survivors:
  - Register-exchange, TB_DEPTH bits per state.
  - Each new survivor = the chosen predecessor's survivor shifted, with the new bit b appended.
- Output:
  - Best state is the one with minimum new metric; on a tie, the lowest state index.
  - dec_d_o = oldest bit of the best state's survivor, registered.
  - This bit is the information bit from TB_DEPTH−1 symbols before the symbol just consumed.
- dec_valid_o:
  - Asserted the cycle after the enabled cycle in which the decoder has consumed ≥ TB_DEPTH symbols since reset.
  - Low on cycles following a disabled cycle.
  - The symbol counter saturates at TB_DEPTH.
- When dec_enable_i = 0: metrics, survivors, counter and dec_d_o hold.

Reset and initial conditions:
- Reset outputs: dec_d_o = 0, dec_valid_o = 0.
- Reset overrides everything in the same cycle; a mid-stream reset returns both paths to their initial conditions.
- Enable may be asserted in the first cycle after reset is released.

Error correction:
- Free distance is 5: any 2 symbol-bit errors within a 5-symbol window must be corrected.
- Requirement: error-free output for a pattern flipping p1 in 2 consecutive symbols out of every 16.

End-to-end:
- Encoder output fed to the decoder through one pipeline register gives dec_d_o equal to enc_d_i delayed by TB_DEPTH+2 cycles under continuous enable.

Test Plan:
1. Encoder vector:
   - Stimulus: after reset, enable high, inputs 1,0,1,1,0,0.
   - Response: enc_d_o = 11,10,00,01,01,11, each on the cycle after its input; enc_valid_o high.
2. All-zero stream:
   - Stimulus: 64 zero bits through encoder → register → decoder.
   - Response: enc_d_o always 00; dec_valid_o rises after TB_DEPTH symbols; dec_d_o always 0.
3. Error-free loopback:
   - Stimulus: 256 pseudo-random bits (LFSR).
   - Response: decoded bits equal the inputs delayed by TB_DEPTH+2 cycles; 0 mismatches.
4. Error injection:
   - Stimulus: same stream, with p1 XOR-flipped whenever word_count[3:1] = 111 (2 of every 16 symbols).
   - Response: 0 decoded mismatches.
5. Enable gaps:
   - Stimulus: deassert both enables for 3 cycles mid-stream.
   - Response: outputs hold; valid flags low during the gap; decoded sequence is unchanged once resumed.
6. Mid-stream reset:
   - Stimulus: assert rst for 1 cycle at symbol 100.
   - Response: next cycle enc_d_o = 00, dec_valid_o = 0, metrics reset; the following stream decodes correctly after TB_DEPTH symbols.
